// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - frame geometry and stream FSM state type for the image pixel streamer
package img_pkg;
   localparam int IMG_W      = 640;
   localparam int IMG_H      = 480;
   localparam int IMG_PIXELS = IMG_W * IMG_H;
   localparam int ADDR_W     = 20;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2
   } stream_state_t;
endpackage

// File: rtl/pix_raster_counter.sv
// rtl/pix_raster_counter.sv - raster x/y/linear-address counter with wrap and last-pixel flag
module pix_raster_counter #(
   parameter int W  = img_pkg::IMG_W,
   parameter int H  = img_pkg::IMG_H,
   parameter int AW = img_pkg::ADDR_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          enable,
   output logic [9:0]    x,
   output logic [8:0]    y,
   output logic [AW-1:0] addr,
   output logic          rowEnd,
   output logic          last
);
   import img_pkg::*;

   localparam logic [9:0] X_LAST = 10'(W - 1);
   localparam logic [8:0] Y_LAST = 9'(H - 1);

   assign rowEnd = (x == X_LAST);
   assign last   = rowEnd && (y == Y_LAST);

   // Holding on the last pixel keeps the address inside the image.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x    <= '0;
         y    <= '0;
         addr <= '0;
      end else if (clear) begin
         x    <= '0;
         y    <= '0;
         addr <= '0;
      end else if (enable && !last) begin
         addr <= addr + 1'b1;
         if (rowEnd) begin
            x <= '0;
            y <= y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end
endmodule

// File: rtl/image_pixel_streamer.sv
// rtl/image_pixel_streamer.sv - raster reader turning image memory bytes into a valid/ready pixel stream
module image_pixel_streamer #(
   parameter int IMG_W  = img_pkg::IMG_W,
   parameter int IMG_H  = img_pkg::IMG_H,
   parameter int ADDR_W = img_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_data,
   output logic [7:0]        pix_data,
   output logic [9:0]        pix_x,
   output logic [8:0]        pix_y,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              pix_eol,
   output logic              pix_eof,
   output logic              busy,
   output logic              done
);
   import img_pkg::*;

   stream_state_t state, nextState;

   logic              fetchEn;
   logic              cntClear;
   logic [9:0]        fetchX;
   logic [8:0]        fetchY;
   logic [ADDR_W-1:0] fetchAddr;
   logic              fetchRowEnd;
   logic              fetchLast;
   logic [23:0]       unusedMemBits;

   assign unusedMemBits = mem_data[31:8];
   assign mem_addr      = fetchAddr;

   pix_raster_counter #(
      .W  (IMG_W),
      .H  (IMG_H),
      .AW (ADDR_W)
   ) fetchCounter (
      .clk    (clk),
      .rst    (rst),
      .clear  (cntClear),
      .enable (fetchEn),
      .x      (fetchX),
      .y      (fetchY),
      .addr   (fetchAddr),
      .rowEnd (fetchRowEnd),
      .last   (fetchLast)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   // FLUSH lingers one cycle with the output empty so done coincides with busy still high.
   always_comb begin
      nextState = state;
      busy      = 1'b1;
      done      = 1'b0;
      fetchEn   = 1'b0;
      cntClear  = 1'b0;
      case (state)
         IDLE: begin
            busy     = 1'b0;
            cntClear = 1'b1;
            if (start) nextState = STREAM;
         end
         STREAM: begin
            fetchEn = !pix_valid || pix_ready;
            if (fetchEn && fetchLast) nextState = FLUSH;
         end
         FLUSH: begin
            if (!pix_valid) begin
               done      = 1'b1;
               cntClear  = 1'b1;
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_data  <= '0;
         pix_x     <= '0;
         pix_y     <= '0;
         pix_valid <= 1'b0;
         pix_eol   <= 1'b0;
         pix_eof   <= 1'b0;
      end else if (fetchEn) begin
         pix_data  <= mem_data[7:0];
         pix_x     <= fetchX;
         pix_y     <= fetchY;
         pix_valid <= 1'b1;
         pix_eol   <= fetchRowEnd;
         pix_eof   <= fetchLast;
      end else if (pix_valid && pix_ready) begin
         pix_valid <= 1'b0;
      end
   end
endmodule
